waylookup_consumer: RTL and testbench
=====================================

Name: waylookup_consumer

Overview:
- Read-side consumer of the ICache WayLookup queue, placed in the ICache main pipe at stages s0/s1.
- Pairs each FTQ fetch request with the head WayLookup entry and pops that entry.
- Holds the pair in an s1 register and keeps the held entry coherent with refill updates until the downstream data stage accepts it.
- Flags any vSetIdx mismatch between the fetch request and the popped entry.

Parameters:
- SET_W, 8, virtual set index width
- WAY_N, 4, ways per set (waymask width)
- PTAG_W, 36, physical tag width
- BLK_W, 42, block physical address width (blkPaddr)
- GPA_W, 56, guest physical address width
- CNT_W, 16, stall counter width

Ports:
- clock  in  1  core clock
- reset  in  1  asynchronous, active-low reset
- io_flush  in  1  pipeline flush
- io_req_valid  in  1  FTQ fetch request valid
- io_req_ready  out  1  FTQ fetch request accepted
- io_req_vSetIdx_0/1  in  SET_W  request set index, port 0 and port 1
- io_req_doubleline  in  1  request spans two cache lines
- io_wl_valid  in  1  WayLookup read valid
- io_wl_ready  out  1  WayLookup read pop
- io_wl_vSetIdx_0/1  in  SET_W  entry set index
- io_wl_waymask_0/1  in  WAY_N  entry way hit mask
- io_wl_ptag_0/1  in  PTAG_W  entry physical tag
- io_wl_exception_0/1, io_wl_pbmt_0/1  in  2  ITLB exception and pbmt
- io_wl_meta_codes_0/1  in  1  meta parity
- io_wl_gpaddr  in  GPA_W  gpf guest physical address
- io_wl_isForVSnonLeafPTE  in  1  gpf flag
- io_update_valid  in  1  refill update valid
- io_update_blkPaddr  in  BLK_W  refilled block address
- io_update_vSetIdx  in  SET_W  refilled set
- io_update_waymask  in  WAY_N  refilled way
- io_update_corrupt  in  1  refill data corrupt
- io_s1_valid  out  1  s1 holds a paired entry
- io_s1_ready  in  1  data stage accepts s1
- io_s1_* (vSetIdx, waymask, ptag, exception, pbmt, meta_codes for ports 0/1; gpaddr; isForVSnonLeafPTE; doubleline)  out  same widths as io_wl_*  held entry
- io_s1_corrupt_0/1  out  1  held line refilled corrupt
- io_mismatch  out  1  one-cycle pulse: request/entry set mismatch
- io_stall_cnt  out  CNT_W  saturating count of cycles with io_req_valid & !io_wl_valid

Behaviour:
- Reset (async, reset==0): all outputs 0, s1 register empty, counter 0.
- s1_free = !s1_valid | io_s1_ready.
- io_req_ready = io_wl_ready = io_req_valid & io_wl_valid & s1_free & !io_flush. Both sides fire together; never fire one alone.
- On fire, the next cycle has s1_valid=1 and the captured fields. Latency is 1 cycle.
- If s1 is held and !io_s1_ready, the entry is held unchanged except for update effects.
- Update effect, applied per port p to the held entry and bypassed onto an entry captured the same cycle. Let u_tag = io_update_blkPaddr[BLK_W-1:BLK_W-PTAG_W].
  - Hit case (vSetIdx_p==io_update_vSetIdx and ptag_p==u_tag): waymask_p <= io_update_waymask; meta_codes_p <= ^u_tag; corrupt_p <= io_update_corrupt.
  - Eviction case (vSetIdx match, ptag differs, waymask_p==io_update_waymask): waymask_p <= 0; corrupt_p <= 0.
  - Port 1 is updated only when doubleline=1.
- io_mismatch = fire & (req.vSetIdx_0!=wl.vSetIdx_0 | (doubleline & req.vSetIdx_1!=wl.vSetIdx_1)), registered. The entry is still captured.
- Flush: s1_valid <= 0 next cycle; no fire in the flush cycle; an update arriving in the same cycle is ignored. The stall counter is not cleared.
- A simultaneous s1 drain (io_s1_ready) and new fire refills s1 back-to-back; sustained throughput is 1 entry/cycle.
- Stall counter saturates at all-ones and never wraps.

Decomposition:
- Shared package icache_pkg:
  - widths SET_W, WAY_N, PTAG_W, BLK_W, GPA_W
  - typedef wl_entry_t (per-port vSetIdx/waymask/ptag/exception/pbmt/meta_codes)
  - typedef wl_gpf_t
  - typedef wl_update_t
- One sub-module, waylookup_entry_update: a combinational per-port hit/evict update, instanced twice for s1 and twice for the bypass path.

Test Plan:
- Reset then req(vSetIdx0=0x12) with wl(vSetIdx0=0x12, waymask0=0b0100), s1_ready=1 -> next cycle s1_valid=1, waymask0=0b0100, mismatch=0.
- s1 held (s1_ready=0), then update(vSetIdx=0x12, blkPaddr tag=ptag0, waymask=0b0001, corrupt=1) -> s1 waymask0=0b0001, corrupt_0=1, meta_codes0=^ptag0.
- Held entry waymask0=0b0100, update with same set, different tag, waymask=0b0100 -> waymask0=0; with doubleline=0 port 1 unchanged.
- Request valid for 5 cycles with wl_valid=0 -> io_stall_cnt=5, req_ready=0; then wl_valid=1 -> fire, counter holds at 5.
- Fire with req vSetIdx0=0x12, wl vSetIdx0=0x13 -> mismatch pulses 1 cycle; flush asserted while s1_valid -> s1_valid=0 next cycle, no pop during flush.
- Continuous valid on both sides with s1_ready=1 for 8 cycles -> 8 pops, 8 s1 beats, no bubble; async reset mid-stream -> s1_valid=0 immediately.

Source files
------------

// File: rtl/waylookup_consumer_pkg.sv
// icache_pkg: shared widths and types for the ICache WayLookup consumer.
//   wl_port_t   - one cache-line half of a WayLookup entry
//   wl_entry_t  - both ports of an entry
//   wl_gpf_t    - guest-page-fault side information
//   wl_update_t - refill update, already reduced to the physical tag
package icache_pkg;

   localparam int unsigned SET_W  = 8;
   localparam int unsigned WAY_N  = 4;
   localparam int unsigned PTAG_W = 36;
   localparam int unsigned BLK_W  = 42;
   localparam int unsigned GPA_W  = 56;
   localparam int unsigned CNT_W  = 16;

   typedef struct packed {
      logic [SET_W-1:0]  vSetIdx;
      logic [WAY_N-1:0]  waymask;
      logic [PTAG_W-1:0] ptag;
      logic [1:0]        exception;
      logic [1:0]        pbmt;
      logic              meta_codes;
   } wl_port_t;

   typedef struct packed {
      wl_port_t [1:0] port;
   } wl_entry_t;

   typedef struct packed {
      logic [GPA_W-1:0] gpaddr;
      logic             isForVSnonLeafPTE;
   } wl_gpf_t;

   typedef struct packed {
      logic              valid;
      logic [PTAG_W-1:0] tag;
      logic [SET_W-1:0]  vSetIdx;
      logic [WAY_N-1:0]  waymask;
      logic              corrupt;
   } wl_update_t;

   // The tag of a refilled block is the top PTAG_W bits of its block address.
   function automatic logic [PTAG_W-1:0] blk_tag(input logic [BLK_W-1:0] blk);
      return blk[BLK_W-1 -: PTAG_W];
   endfunction

endpackage

// File: rtl/waylookup_consumer_if.sv
// waylookup_consumer_if: all handshake/bus signals of the WayLookup consumer.
//   req_*    FTQ fetch request            (slave: in, except req_ready)
//   wl_*     WayLookup head entry         (slave: in, except wl_ready)
//   update_* refill update                (slave: in)
//   s1_*     held s1 entry to data stage  (slave: out, except s1_ready)
//   flush, mismatch, stall_cnt            control / status
interface waylookup_consumer_if;
   import icache_pkg::*;

   logic              flush;

   logic              req_valid;
   logic              req_ready;
   logic [SET_W-1:0]  req_vSetIdx_0;
   logic [SET_W-1:0]  req_vSetIdx_1;
   logic              req_doubleline;

   logic              wl_valid;
   logic              wl_ready;
   logic [SET_W-1:0]  wl_vSetIdx_0;
   logic [SET_W-1:0]  wl_vSetIdx_1;
   logic [WAY_N-1:0]  wl_waymask_0;
   logic [WAY_N-1:0]  wl_waymask_1;
   logic [PTAG_W-1:0] wl_ptag_0;
   logic [PTAG_W-1:0] wl_ptag_1;
   logic [1:0]        wl_exception_0;
   logic [1:0]        wl_exception_1;
   logic [1:0]        wl_pbmt_0;
   logic [1:0]        wl_pbmt_1;
   logic              wl_meta_codes_0;
   logic              wl_meta_codes_1;
   logic [GPA_W-1:0]  wl_gpaddr;
   logic              wl_isForVSnonLeafPTE;

   logic              update_valid;
   logic [BLK_W-1:0]  update_blkPaddr;
   logic [SET_W-1:0]  update_vSetIdx;
   logic [WAY_N-1:0]  update_waymask;
   logic              update_corrupt;

   logic              s1_valid;
   logic              s1_ready;
   logic [SET_W-1:0]  s1_vSetIdx_0;
   logic [SET_W-1:0]  s1_vSetIdx_1;
   logic [WAY_N-1:0]  s1_waymask_0;
   logic [WAY_N-1:0]  s1_waymask_1;
   logic [PTAG_W-1:0] s1_ptag_0;
   logic [PTAG_W-1:0] s1_ptag_1;
   logic [1:0]        s1_exception_0;
   logic [1:0]        s1_exception_1;
   logic [1:0]        s1_pbmt_0;
   logic [1:0]        s1_pbmt_1;
   logic              s1_meta_codes_0;
   logic              s1_meta_codes_1;
   logic [GPA_W-1:0]  s1_gpaddr;
   logic              s1_isForVSnonLeafPTE;
   logic              s1_doubleline;
   logic              s1_corrupt_0;
   logic              s1_corrupt_1;

   logic              mismatch;
   logic [CNT_W-1:0]  stall_cnt;

   modport slave (
      input  flush,
      input  req_valid, req_vSetIdx_0, req_vSetIdx_1, req_doubleline,
      output req_ready,
      input  wl_valid, wl_vSetIdx_0, wl_vSetIdx_1, wl_waymask_0, wl_waymask_1,
             wl_ptag_0, wl_ptag_1, wl_exception_0, wl_exception_1,
             wl_pbmt_0, wl_pbmt_1, wl_meta_codes_0, wl_meta_codes_1,
             wl_gpaddr, wl_isForVSnonLeafPTE,
      output wl_ready,
      input  update_valid, update_blkPaddr, update_vSetIdx, update_waymask,
             update_corrupt,
      input  s1_ready,
      output s1_valid, s1_vSetIdx_0, s1_vSetIdx_1, s1_waymask_0, s1_waymask_1,
             s1_ptag_0, s1_ptag_1, s1_exception_0, s1_exception_1,
             s1_pbmt_0, s1_pbmt_1, s1_meta_codes_0, s1_meta_codes_1,
             s1_gpaddr, s1_isForVSnonLeafPTE, s1_doubleline,
             s1_corrupt_0, s1_corrupt_1,
      output mismatch, stall_cnt
   );

   modport master (
      output flush,
      output req_valid, req_vSetIdx_0, req_vSetIdx_1, req_doubleline,
      input  req_ready,
      output wl_valid, wl_vSetIdx_0, wl_vSetIdx_1, wl_waymask_0, wl_waymask_1,
             wl_ptag_0, wl_ptag_1, wl_exception_0, wl_exception_1,
             wl_pbmt_0, wl_pbmt_1, wl_meta_codes_0, wl_meta_codes_1,
             wl_gpaddr, wl_isForVSnonLeafPTE,
      input  wl_ready,
      output update_valid, update_blkPaddr, update_vSetIdx, update_waymask,
             update_corrupt,
      output s1_ready,
      input  s1_valid, s1_vSetIdx_0, s1_vSetIdx_1, s1_waymask_0, s1_waymask_1,
             s1_ptag_0, s1_ptag_1, s1_exception_0, s1_exception_1,
             s1_pbmt_0, s1_pbmt_1, s1_meta_codes_0, s1_meta_codes_1,
             s1_gpaddr, s1_isForVSnonLeafPTE, s1_doubleline,
             s1_corrupt_0, s1_corrupt_1,
      input  mismatch, stall_cnt
   );

endinterface

// File: rtl/waylookup_consumer_entry_update.sv
// waylookup_entry_update: combinational refill-update of one entry port.
//   port_i/corrupt_i  current port fields and corrupt flag
//   en_i              port participates (port 1 only for doubleline)
//   upd_i             refill update (valid already gated by flush)
//   port_o/corrupt_o  port fields after the update
// Same set + same tag: the line was refilled into upd_i.waymask.
// Same set + other tag + same way: the line we pointed at was evicted.
module waylookup_entry_update
   import icache_pkg::*;
(
   input  wl_port_t   port_i,
   input  logic       corrupt_i,
   input  logic       en_i,
   input  wl_update_t upd_i,
   output wl_port_t   port_o,
   output logic       corrupt_o
);

   logic set_hit;
   logic tag_hit;
   logic way_hit;

   always_comb begin
      set_hit   = en_i & upd_i.valid & (port_i.vSetIdx == upd_i.vSetIdx);
      tag_hit   = (port_i.ptag == upd_i.tag);
      way_hit   = (port_i.waymask == upd_i.waymask);
      port_o    = port_i;
      corrupt_o = corrupt_i;
      if (set_hit && tag_hit) begin
         port_o.waymask    = upd_i.waymask;
         port_o.meta_codes = ^upd_i.tag;
         corrupt_o         = upd_i.corrupt;
      end else if (set_hit && way_hit) begin
         port_o.waymask = '0;
         corrupt_o      = 1'b0;
      end
   end

endmodule

// File: rtl/waylookup_consumer.sv
// waylookup_consumer: ICache main-pipe s0/s1 reader of the WayLookup queue.
//   clock, reset (async, active low)
//   io (waylookup_consumer_if.slave): request/WayLookup handshake, refill
//   update, held s1 entry, set-mismatch pulse and saturating stall counter.
// A request and the head WayLookup entry fire together into the s1 register;
// the held entry tracks refill updates until the data stage takes it.
module waylookup_consumer
   import icache_pkg::*;
(
   input logic               clock,
   input logic               reset,
   waylookup_consumer_if.slave io
);

   wl_entry_t        wl_in;
   wl_entry_t        held_upd;
   wl_entry_t        byp_upd;
   logic [1:0]       corrupt_held;
   logic [1:0]       corrupt_byp;
   logic [1:0]       en_held;
   logic [1:0]       en_byp;
   wl_update_t       upd;

   logic             s1_free;
   logic             fire;

   logic             s1_valid_q,  s1_valid_d;
   wl_entry_t        entry_q,     entry_d;
   logic [1:0]       corrupt_q,   corrupt_d;
   wl_gpf_t          gpf_q,       gpf_d;
   logic             dbl_q,       dbl_d;
   logic             mismatch_q,  mismatch_d;
   logic [CNT_W-1:0] cnt_q,       cnt_d;

   always_comb begin
      wl_in.port[0] = '{vSetIdx: io.wl_vSetIdx_0, waymask: io.wl_waymask_0,
                        ptag: io.wl_ptag_0, exception: io.wl_exception_0,
                        pbmt: io.wl_pbmt_0, meta_codes: io.wl_meta_codes_0};
      wl_in.port[1] = '{vSetIdx: io.wl_vSetIdx_1, waymask: io.wl_waymask_1,
                        ptag: io.wl_ptag_1, exception: io.wl_exception_1,
                        pbmt: io.wl_pbmt_1, meta_codes: io.wl_meta_codes_1};
      // A flush discards any same-cycle refill update.
      upd = '{valid: io.update_valid & ~io.flush,
              tag: blk_tag(io.update_blkPaddr),
              vSetIdx: io.update_vSetIdx,
              waymask: io.update_waymask,
              corrupt: io.update_corrupt};
      en_held = {dbl_q, 1'b1};
      en_byp  = {io.req_doubleline, 1'b1};
   end

   // One update path for the held entry, one bypass path for a fresh capture.
   for (genvar p = 0; p < 2; p++) begin : g_port
      waylookup_entry_update u_held (
         .port_i    (entry_q.port[p]),
         .corrupt_i (corrupt_q[p]),
         .en_i      (en_held[p]),
         .upd_i     (upd),
         .port_o    (held_upd.port[p]),
         .corrupt_o (corrupt_held[p])
      );
      waylookup_entry_update u_byp (
         .port_i    (wl_in.port[p]),
         .corrupt_i (1'b0),
         .en_i      (en_byp[p]),
         .upd_i     (upd),
         .port_o    (byp_upd.port[p]),
         .corrupt_o (corrupt_byp[p])
      );
   end

   always_comb begin
      s1_free    = ~s1_valid_q | io.s1_ready;
      fire       = io.req_valid & io.wl_valid & s1_free & ~io.flush;

      s1_valid_d = s1_valid_q;
      entry_d    = held_upd;
      corrupt_d  = corrupt_held;
      gpf_d      = gpf_q;
      dbl_d      = dbl_q;
      if (io.flush) begin
         s1_valid_d = 1'b0;
      end else if (fire) begin
         s1_valid_d = 1'b1;
         entry_d    = byp_upd;
         corrupt_d  = corrupt_byp;
         gpf_d      = '{gpaddr: io.wl_gpaddr,
                        isForVSnonLeafPTE: io.wl_isForVSnonLeafPTE};
         dbl_d      = io.req_doubleline;
      end else if (io.s1_ready) begin
         s1_valid_d = 1'b0;
      end

      mismatch_d = fire & ((io.req_vSetIdx_0 != io.wl_vSetIdx_0) |
                           (io.req_doubleline & (io.req_vSetIdx_1 != io.wl_vSetIdx_1)));

      cnt_d = cnt_q;
      if (io.req_valid && !io.wl_valid && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         s1_valid_q <= 1'b0;
         entry_q    <= '0;
         corrupt_q  <= '0;
         gpf_q      <= '0;
         dbl_q      <= 1'b0;
         mismatch_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         entry_q    <= entry_d;
         corrupt_q  <= corrupt_d;
         gpf_q      <= gpf_d;
         dbl_q      <= dbl_d;
         mismatch_q <= mismatch_d;
         cnt_q      <= cnt_d;
      end
   end

   assign io.req_ready            = fire;
   assign io.wl_ready             = fire;
   assign io.s1_valid             = s1_valid_q;
   assign io.s1_vSetIdx_0         = entry_q.port[0].vSetIdx;
   assign io.s1_vSetIdx_1         = entry_q.port[1].vSetIdx;
   assign io.s1_waymask_0         = entry_q.port[0].waymask;
   assign io.s1_waymask_1         = entry_q.port[1].waymask;
   assign io.s1_ptag_0            = entry_q.port[0].ptag;
   assign io.s1_ptag_1            = entry_q.port[1].ptag;
   assign io.s1_exception_0       = entry_q.port[0].exception;
   assign io.s1_exception_1       = entry_q.port[1].exception;
   assign io.s1_pbmt_0            = entry_q.port[0].pbmt;
   assign io.s1_pbmt_1            = entry_q.port[1].pbmt;
   assign io.s1_meta_codes_0      = entry_q.port[0].meta_codes;
   assign io.s1_meta_codes_1      = entry_q.port[1].meta_codes;
   assign io.s1_gpaddr            = gpf_q.gpaddr;
   assign io.s1_isForVSnonLeafPTE = gpf_q.isForVSnonLeafPTE;
   assign io.s1_doubleline        = dbl_q;
   assign io.s1_corrupt_0         = corrupt_q[0];
   assign io.s1_corrupt_1         = corrupt_q[1];
   assign io.mismatch             = mismatch_q;
   assign io.stall_cnt            = cnt_q;

endmodule

// File: tb/tb_waylookup_consumer.sv
// Directed self-checking bench for waylookup_consumer.
module tb_waylookup_consumer;
   import icache_pkg::*;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   waylookup_consumer_if bus();

   waylookup_consumer dut (
      .clock (clock),
      .reset (reset),
      .io    (bus)
   );

   localparam logic [PTAG_W-1:0] PT0 = 36'hA_BCDE_F012;
   localparam logic [PTAG_W-1:0] PT1 = 36'h5_1234_5678;
   localparam logic [PTAG_W-1:0] PTX = 36'h3_0000_0001;

   int n_pass  = 0;
   int n_total = 0;

   task automatic step;
      @(posedge clock);
      #1;
   endtask

   task automatic set_wl(input logic [SET_W-1:0] s0, input logic [SET_W-1:0] s1,
                         input logic [WAY_N-1:0] w0, input logic [WAY_N-1:0] w1,
                         input logic [PTAG_W-1:0] p0, input logic [PTAG_W-1:0] p1);
      bus.wl_vSetIdx_0 = s0;
      bus.wl_vSetIdx_1 = s1;
      bus.wl_waymask_0 = w0;
      bus.wl_waymask_1 = w1;
      bus.wl_ptag_0    = p0;
      bus.wl_ptag_1    = p1;
   endtask

   task automatic clear_inputs;
      bus.flush = 1'b0;
      bus.req_valid = 1'b0; bus.req_vSetIdx_0 = '0; bus.req_vSetIdx_1 = '0;
      bus.req_doubleline = 1'b0;
      bus.wl_valid = 1'b0;
      set_wl('0, '0, '0, '0, '0, '0);
      bus.wl_exception_0 = '0; bus.wl_exception_1 = '0;
      bus.wl_pbmt_0 = '0; bus.wl_pbmt_1 = '0;
      bus.wl_meta_codes_0 = 1'b0; bus.wl_meta_codes_1 = 1'b0;
      bus.wl_gpaddr = '0; bus.wl_isForVSnonLeafPTE = 1'b0;
      bus.update_valid = 1'b0; bus.update_blkPaddr = '0; bus.update_vSetIdx = '0;
      bus.update_waymask = '0; bus.update_corrupt = 1'b0;
      bus.s1_ready = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b0;
      clear_inputs();
      repeat (2) @(posedge clock);
      #1;
      n_total++; if (bus.s1_valid !== 1'b0) $display("FAIL reset_s1_valid: got %0b want 0", bus.s1_valid); else n_pass++;
      n_total++; if (bus.mismatch !== 1'b0) $display("FAIL reset_mismatch: got %0b want 0", bus.mismatch); else n_pass++;
      n_total++; if (bus.stall_cnt !== 16'd0) $display("FAIL reset_stall_cnt: got %0d want 0", bus.stall_cnt); else n_pass++;
      n_total++; if (bus.s1_waymask_0 !== 4'd0) $display("FAIL reset_waymask0: got %b want 0000", bus.s1_waymask_0); else n_pass++;
      @(negedge clock);
      reset = 1'b1;
      step();
   endtask

   task automatic test_fire_basic;
      set_wl(8'h12, 8'h34, 4'b0100, 4'b0010, PT0, PT1);
      bus.wl_gpaddr = 56'h12_3456_789A_BCDE;
      bus.wl_isForVSnonLeafPTE = 1'b1;
      bus.wl_exception_0 = 2'b01;
      bus.req_vSetIdx_0 = 8'h12;
      bus.req_vSetIdx_1 = 8'h77;
      bus.req_valid = 1'b1;
      bus.wl_valid  = 1'b1;
      bus.s1_ready  = 1'b1;
      #1;
      n_total++; if (bus.req_ready !== 1'b1) $display("FAIL fire_req_ready: got %0b want 1", bus.req_ready); else n_pass++;
      n_total++; if (bus.wl_ready !== 1'b1) $display("FAIL fire_wl_ready: got %0b want 1", bus.wl_ready); else n_pass++;
      step();
      bus.req_valid = 1'b0; bus.wl_valid = 1'b0; bus.s1_ready = 1'b0;
      n_total++; if (bus.s1_valid !== 1'b1) $display("FAIL fire_s1_valid: got %0b want 1", bus.s1_valid); else n_pass++;
      n_total++; if (bus.s1_waymask_0 !== 4'b0100) $display("FAIL fire_waymask0: got %b want 0100", bus.s1_waymask_0); else n_pass++;
      n_total++; if (bus.s1_ptag_0 !== PT0) $display("FAIL fire_ptag0: got %h want %h", bus.s1_ptag_0, PT0); else n_pass++;
      n_total++; if (bus.s1_gpaddr !== 56'h12_3456_789A_BCDE) $display("FAIL fire_gpaddr: got %h want 123456789abcde", bus.s1_gpaddr); else n_pass++;
      n_total++; if (bus.s1_exception_0 !== 2'b01) $display("FAIL fire_exception0: got %b want 01", bus.s1_exception_0); else n_pass++;
      n_total++; if (bus.mismatch !== 1'b0) $display("FAIL fire_mismatch: got %0b want 0", bus.mismatch); else n_pass++;
   endtask

   task automatic test_update_hit;
      logic [PTAG_W-1:0] t;
      step();
      n_total++; if (bus.s1_valid !== 1'b1 || bus.s1_waymask_0 !== 4'b0100) $display("FAIL hold_entry: got valid %0b waymask %b want 1 0100", bus.s1_valid, bus.s1_waymask_0); else n_pass++;
      bus.update_valid = 1'b1; bus.update_vSetIdx = 8'h12;
      bus.update_blkPaddr = {PT0, 6'h15}; bus.update_waymask = 4'b0001; bus.update_corrupt = 1'b1;
      step();
      bus.update_valid = 1'b0;
      t = PT0;
      n_total++; if (bus.s1_waymask_0 !== 4'b0001) $display("FAIL hit_waymask0: got %b want 0001", bus.s1_waymask_0); else n_pass++;
      n_total++; if (bus.s1_corrupt_0 !== 1'b1) $display("FAIL hit_corrupt0: got %0b want 1", bus.s1_corrupt_0); else n_pass++;
      n_total++; if (bus.s1_meta_codes_0 !== ^t) $display("FAIL hit_meta0: got %0b want %0b", bus.s1_meta_codes_0, ^t); else n_pass++;
      n_total++; if (bus.s1_waymask_1 !== 4'b0010) $display("FAIL hit_port1_untouched: got %b want 0010", bus.s1_waymask_1); else n_pass++;
   endtask

   task automatic test_update_evict;
      set_wl(8'h12, 8'h12, 4'b0100, 4'b0100, PT0, PT1);
      bus.req_vSetIdx_0 = 8'h12; bus.req_doubleline = 1'b0;
      bus.req_valid = 1'b1; bus.wl_valid = 1'b1; bus.s1_ready = 1'b1;
      step();
      bus.req_valid = 1'b0; bus.wl_valid = 1'b0; bus.s1_ready = 1'b0;
      n_total++; if (bus.s1_waymask_0 !== 4'b0100 || bus.s1_corrupt_0 !== 1'b0) $display("FAIL evict_capture: got waymask %b corrupt %0b want 0100 0", bus.s1_waymask_0, bus.s1_corrupt_0); else n_pass++;
      bus.update_valid = 1'b1; bus.update_vSetIdx = 8'h12;
      bus.update_blkPaddr = {PTX, 6'h00}; bus.update_waymask = 4'b0100; bus.update_corrupt = 1'b1;
      step();
      bus.update_valid = 1'b0;
      n_total++; if (bus.s1_waymask_0 !== 4'b0000) $display("FAIL evict_waymask0: got %b want 0000", bus.s1_waymask_0); else n_pass++;
      n_total++; if (bus.s1_corrupt_0 !== 1'b0) $display("FAIL evict_corrupt0: got %0b want 0", bus.s1_corrupt_0); else n_pass++;
      n_total++; if (bus.s1_waymask_1 !== 4'b0100) $display("FAIL evict_port1_single: got %b want 0100", bus.s1_waymask_1); else n_pass++;
      n_total++; if (bus.s1_ptag_0 !== PT0) $display("FAIL evict_ptag0: got %h want %h", bus.s1_ptag_0, PT0); else n_pass++;
   endtask

   task automatic test_bypass_doubleline;
      logic [PTAG_W-1:0] t;
      set_wl(8'h40, 8'h42, 4'b0001, 4'b0010, PT0, PT1);
      bus.req_vSetIdx_0 = 8'h40; bus.req_vSetIdx_1 = 8'h41; bus.req_doubleline = 1'b1;
      bus.req_valid = 1'b1; bus.wl_valid = 1'b1; bus.s1_ready = 1'b1;
      bus.update_valid = 1'b1; bus.update_vSetIdx = 8'h42;
      bus.update_blkPaddr = {PT1, 6'h3F}; bus.update_waymask = 4'b1000; bus.update_corrupt = 1'b1;
      step();
      bus.req_valid = 1'b0; bus.wl_valid = 1'b0; bus.s1_ready = 1'b0;
      bus.update_valid = 1'b0; bus.req_doubleline = 1'b0;
      t = PT1;
      n_total++; if (bus.s1_waymask_1 !== 4'b1000) $display("FAIL byp_waymask1: got %b want 1000", bus.s1_waymask_1); else n_pass++;
      n_total++; if (bus.s1_corrupt_1 !== 1'b1) $display("FAIL byp_corrupt1: got %0b want 1", bus.s1_corrupt_1); else n_pass++;
      n_total++; if (bus.s1_meta_codes_1 !== ^t) $display("FAIL byp_meta1: got %0b want %0b", bus.s1_meta_codes_1, ^t); else n_pass++;
      n_total++; if (bus.s1_waymask_0 !== 4'b0001) $display("FAIL byp_waymask0: got %b want 0001", bus.s1_waymask_0); else n_pass++;
      n_total++; if (bus.s1_doubleline !== 1'b1) $display("FAIL byp_doubleline: got %0b want 1", bus.s1_doubleline); else n_pass++;
      n_total++; if (bus.mismatch !== 1'b1) $display("FAIL byp_mismatch_port1: got %0b want 1", bus.mismatch); else n_pass++;
      step();
      n_total++; if (bus.mismatch !== 1'b0) $display("FAIL byp_mismatch_pulse: got %0b want 0", bus.mismatch); else n_pass++;
   endtask

   task automatic test_stall;
      bus.s1_ready = 1'b1;
      bus.req_vSetIdx_0 = 8'h21;
      bus.req_valid = 1'b1; bus.wl_valid = 1'b0;
      #1;
      n_total++; if (bus.req_ready !== 1'b0) $display("FAIL stall_req_ready: got %0b want 0", bus.req_ready); else n_pass++;
      repeat (5) step();
      n_total++; if (bus.stall_cnt !== 16'd5) $display("FAIL stall_cnt_5: got %0d want 5", bus.stall_cnt); else n_pass++;
      set_wl(8'h21, 8'h00, 4'b0010, 4'b0000, PT1, PT0);
      bus.wl_valid = 1'b1;
      #1;
      n_total++; if (bus.req_ready !== 1'b1) $display("FAIL stall_release_ready: got %0b want 1", bus.req_ready); else n_pass++;
      step();
      bus.req_valid = 1'b0; bus.wl_valid = 1'b0;
      n_total++; if (bus.stall_cnt !== 16'd5) $display("FAIL stall_cnt_hold: got %0d want 5", bus.stall_cnt); else n_pass++;
      n_total++; if (bus.s1_valid !== 1'b1 || bus.s1_vSetIdx_0 !== 8'h21) $display("FAIL stall_fire: got valid %0b set %h want 1 21", bus.s1_valid, bus.s1_vSetIdx_0); else n_pass++;
   endtask

   task automatic test_mismatch_flush;
      bus.s1_ready = 1'b1;
      bus.req_vSetIdx_0 = 8'h12;
      set_wl(8'h13, 8'h00, 4'b0001, 4'b0000, PT0, PT1);
      bus.req_valid = 1'b1; bus.wl_valid = 1'b1;
      step();
      bus.req_valid = 1'b0; bus.wl_valid = 1'b0; bus.s1_ready = 1'b0;
      n_total++; if (bus.mismatch !== 1'b1) $display("FAIL mm_pulse: got %0b want 1", bus.mismatch); else n_pass++;
      n_total++; if (bus.s1_valid !== 1'b1 || bus.s1_vSetIdx_0 !== 8'h13) $display("FAIL mm_captured: got valid %0b set %h want 1 13", bus.s1_valid, bus.s1_vSetIdx_0); else n_pass++;
      step();
      n_total++; if (bus.mismatch !== 1'b0) $display("FAIL mm_one_cycle: got %0b want 0", bus.mismatch); else n_pass++;
      bus.flush = 1'b1; bus.req_valid = 1'b1; bus.wl_valid = 1'b1; bus.s1_ready = 1'b1;
      #1;
      n_total++; if (bus.wl_ready !== 1'b0 || bus.req_ready !== 1'b0) $display("FAIL flush_no_pop: got wl_ready %0b req_ready %0b want 0 0", bus.wl_ready, bus.req_ready); else n_pass++;
      step();
      bus.flush = 1'b0; bus.req_valid = 1'b0; bus.wl_valid = 1'b0;
      n_total++; if (bus.s1_valid !== 1'b0) $display("FAIL flush_s1_valid: got %0b want 0", bus.s1_valid); else n_pass++;
      n_total++; if (bus.stall_cnt !== 16'd5) $display("FAIL flush_keeps_cnt: got %0d want 5", bus.stall_cnt); else n_pass++;
   endtask

   task automatic test_back_to_back;
      int pops  = 0;
      int beats = 0;
      bus.s1_ready = 1'b1;
      bus.req_valid = 1'b1; bus.wl_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         bus.req_vSetIdx_0 = 8'h80 + 8'(i);
         set_wl(8'h80 + 8'(i), 8'h00, 4'b0001, 4'b0000, PT0, PT1);
         #1;
         if (bus.wl_ready === 1'b1) pops++;
         step();
         if (bus.s1_valid === 1'b1 && bus.s1_vSetIdx_0 === 8'h80 + 8'(i)) beats++;
      end
      n_total++; if (pops !== 8) $display("FAIL b2b_pops: got %0d want 8", pops); else n_pass++;
      n_total++; if (beats !== 8) $display("FAIL b2b_beats: got %0d want 8", beats); else n_pass++;
      step();
      n_total++; if (bus.s1_valid !== 1'b1) $display("FAIL b2b_streaming: got %0b want 1", bus.s1_valid); else n_pass++;
      #2;
      reset = 1'b0;
      #1;
      n_total++; if (bus.s1_valid !== 1'b0) $display("FAIL async_reset_s1_valid: got %0b want 0", bus.s1_valid); else n_pass++;
      n_total++; if (bus.stall_cnt !== 16'd0) $display("FAIL async_reset_cnt: got %0d want 0", bus.stall_cnt); else n_pass++;
      bus.req_valid = 1'b0; bus.wl_valid = 1'b0;
      step();
      reset = 1'b1;
      step();
   endtask

   initial begin
      test_reset();
      test_fire_basic();
      test_update_hit();
      test_update_evict();
      test_bypass_doubleline();
      test_stall();
      test_mismatch_flush();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
